// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for a multicycle RV32I-style datapath.
//
// Purpose:
//   Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] per instruction and
//   drives the datapath strobes and mux selects. It traps on an illegal
//   opcode or when a memory request waits too long for memReady. TRAP is
//   sticky and only rst leaves it.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   opcode[6:0]      instruction opcode, sampled in DECODE only
//   memReady         memory completion for the current request
//   branchTaken      ALU compare result, sampled in EXEC only
//   memReq/memWrite  memory request and its store qualifier
//   irWriteEnable    instruction-register load strobe
//   regsWriteEnable  register-file write strobe
//   pcWriteEnable    PC update strobe
//   pcSel[1:0]       0 = PC+4, 1 = PC+imm, 2 = ALU result
//   aluXSel          0 = rs1, 1 = PC
//   aluYSel[1:0]     0 = rs2, 1 = imm, 2 = constant 4
//   wbSel[1:0]       0 = ALU, 1 = memory data, 2 = PC+4, 3 = imm
//   trap             sticky fault flag
//   trapCause[1:0]   0 = none, 1 = illegal opcode, 2 = memory timeout
//   instret[31:0]    retired-instruction count (one per PC update)
//   state_dbg[2:0]   current FSM state
//
// Handshake: memReq stays high from the first cycle of a FETCH or MEM
// visit until the cycle in which memReady is seen high. That cycle
// completes the transfer. Only rst or a timeout drops memReq before
// completion.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        memReady,
  input  logic        branchTaken,
  output logic        memReq,
  output logic        memWrite,
  output logic        irWriteEnable,
  output logic        regsWriteEnable,
  output logic        pcWriteEnable,
  output logic [1:0]  pcSel,
  output logic        aluXSel,
  output logic [1:0]  aluYSel,
  output logic [1:0]  wbSel,
  output logic        trap,
  output logic [1:0]  trapCause,
  output logic [31:0] instret,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC,
    C_ILLEGAL
  } op_class_e;

  // Trap fires on the cycle the counter would count its MEM_TIMEOUT-th
  // idle cycle, so compare against MEM_TIMEOUT-1 with memReady still low.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  op_class_e   op_q, op_d, dec_class;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] instret_q, instret_d;

  logic       mem_req_c, mem_write_c, ir_we_c, regs_we_c, pc_we_c, alu_x_sel_c;
  logic [1:0] pc_sel_c, alu_y_sel_c, wb_sel_c;

  always_comb begin
    dec_class = C_ILLEGAL;
    case (opcode)
      7'b0110011: dec_class = C_R;
      7'b0010011: dec_class = C_I;
      7'b0000011: dec_class = C_LOAD;
      7'b0100011: dec_class = C_STORE;
      7'b1100011: dec_class = C_BRANCH;
      7'b1101111: dec_class = C_JAL;
      7'b1100111: dec_class = C_JALR;
      7'b0110111: dec_class = C_LUI;
      7'b0010111: dec_class = C_AUIPC;
      default:    dec_class = C_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_d      = wait_q;
    cause_d     = cause_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_we_c     = 1'b0;
    regs_we_c   = 1'b0;
    pc_we_c     = 1'b0;
    pc_sel_c    = 2'd0;
    alu_x_sel_c = 1'b0;
    alu_y_sel_c = 2'd0;
    wb_sel_c    = 2'd0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (memReady) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        op_d = dec_class;
        if (dec_class == C_ILLEGAL) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op_q)
          C_I, C_LOAD, C_STORE, C_JALR: alu_y_sel_c = 2'd1;
          C_JAL, C_AUIPC: begin
            alu_x_sel_c = 1'b1;
            alu_y_sel_c = 2'd1;
          end
          default: ;
        endcase
        if (op_q == C_BRANCH) begin
          pc_we_c  = 1'b1;
          pc_sel_c = branchTaken ? 2'd1 : 2'd0;
          state_d  = S_FETCH;
          wait_d   = 8'd0;
        end else if (op_q == C_LOAD || op_q == C_STORE) begin
          state_d = S_MEM;
          wait_d  = 8'd0;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req_c   = 1'b1;
        mem_write_c = (op_q == C_STORE);
        if (memReady) begin
          if (op_q == C_STORE) begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
            wait_d  = 8'd0;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WB: begin
        regs_we_c = 1'b1;
        pc_we_c   = 1'b1;
        case (op_q)
          C_JALR:  begin pc_sel_c = 2'd2; wb_sel_c = 2'd2; end
          C_JAL:   begin pc_sel_c = 2'd1; wb_sel_c = 2'd2; end
          C_LOAD:  wb_sel_c = 2'd1;
          C_LUI:   wb_sel_c = 2'd3;
          default: ;
        endcase
        state_d = S_FETCH;
        wait_d  = 8'd0;
      end

      S_TRAP: ;

      default: state_d = S_FETCH;
    endcase
  end

  // rst masks every request/strobe in the cycle it is seen, so an
  // abandoned transfer can never produce a strobe or a count.
  assign memReq          = mem_req_c & ~rst;
  assign memWrite        = mem_write_c & ~rst;
  assign irWriteEnable   = ir_we_c & ~rst;
  assign regsWriteEnable = regs_we_c & ~rst;
  assign pcWriteEnable   = pc_we_c & ~rst;
  assign pcSel           = rst ? 2'd0 : pc_sel_c;
  assign aluXSel         = alu_x_sel_c & ~rst;
  assign aluYSel         = rst ? 2'd0 : alu_y_sel_c;
  assign wbSel           = rst ? 2'd0 : wb_sel_c;
  assign trap            = (state_q == S_TRAP);
  assign trapCause       = cause_q;
  assign instret         = instret_q;
  assign state_dbg       = state_q;

  always_comb begin
    instret_d = instret_q + 32'(pcWriteEnable);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= C_R;
      wait_q    <= 8'd0;
      cause_q   <= 2'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, SHALL set the maximum cycles a memory request may wait for memReady before trapping (range 1..255).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 opcode  input  7  instruction opcode; SHALL be sampled in DECODE only.
REQ-005 memReady  input  1  memory completion for the current request.
REQ-006 branchTaken  input  1  ALU compare result; SHALL be sampled in EXEC only.
REQ-007 memReq  output  1  memory request, held until completion.
REQ-008 memWrite  output  1  store qualifier for memReq.
REQ-009 irWriteEnable  output  1  instruction-register load strobe.
REQ-010 regsWriteEnable  output  1  register-file write strobe.
REQ-011 pcWriteEnable  output  1  PC update strobe.
REQ-012 pcSel  output  2  PC source: 0 = PC+4, 1 = PC+imm, 2 = ALU result.
REQ-013 aluXSel  output  1  ALU X source: 0 = rs1, 1 = PC.
REQ-014 aluYSel  output  2  ALU Y source: 0 = rs2, 1 = imm, 2 = constant 4.
REQ-015 wbSel  output  2  write-back source: 0 = ALU, 1 = memory data, 2 = PC+4, 3 = imm.
REQ-016 trap  output  1  sticky fault flag.
REQ-017 trapCause  output  2  fault cause: 0 = none, 1 = illegal opcode, 2 = memory timeout.
REQ-018 instret  output  32  count of retired instructions.

Function
REQ-019 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP, and SHALL expose no other state.
REQ-020 FETCH: memReq=1 and memWrite=0; on memReady=1, irWriteEnable SHALL pulse high combinationally in that same cycle and the FSM SHALL move to DECODE; otherwise the FSM SHALL stay in FETCH.
REQ-021 DECODE: the FSM SHALL move to EXEC in one cycle when opcode is one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
REQ-022 DECODE: any other opcode SHALL move the FSM to TRAP with trapCause=1.
REQ-023 EXEC select values per opcode:
- R-type: aluXSel=0, aluYSel=0.
- I-ALU, load, store, jalr: aluXSel=0, aluYSel=1.
- branch: aluXSel=0, aluYSel=0.
- jal, auipc: aluXSel=1, aluYSel=1.
- lui: ALU unused.
REQ-024 EXEC next state: load/store SHALL go to MEM; branch SHALL go to FETCH; all others SHALL go to WB.
REQ-025 EXEC with branch opcode: pcWriteEnable=1, and pcSel SHALL be 1 when branchTaken=1, else 0.
REQ-026 MEM: memReq=1, and memWrite=1 only for store; on memReady, load SHALL go to WB and store SHALL go to FETCH with pcWriteEnable=1 and pcSel=0 in that cycle.
REQ-027 WB: regsWriteEnable=1 and pcWriteEnable=1 for exactly one cycle, then the FSM SHALL go to FETCH.
REQ-028 WB pcSel: jalr SHALL use 2, jal SHALL use 1, all others SHALL use 0.
REQ-029 WB wbSel: load SHALL use 1; jal/jalr SHALL use 2; lui SHALL use 3; all others SHALL use 0.
REQ-030 Timeout: a wait counter SHALL clear on entry to FETCH or MEM and increment each cycle memReady=0.
REQ-031 When the wait counter reaches MEM_TIMEOUT, the FSM SHALL go to TRAP with trapCause=2.
REQ-032 A memReady arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL complete the transfer normally.
REQ-033 TRAP: all strobes and memReq SHALL be 0; trap=1; the FSM SHALL leave TRAP only on rst.
REQ-034 instret SHALL increment by 1 on every cycle where pcWriteEnable=1, and SHALL wrap from FFFFFFFF to 0.
REQ-035 Strobes (regsWriteEnable, pcWriteEnable, irWriteEnable) SHALL be 0 in every state and cycle not listed above.
REQ-036 Select outputs not specified for a state SHALL be 0.
REQ-037 memReq SHALL never deassert mid-request except on rst or timeout.
REQ-038 Minimum latency with memReady constant high: R/I/lui/auipc/jal/jalr 4 cycles, load 5, store 4, branch 3.

Reset
REQ-039 With rst=1 at a clock edge, the FSM SHALL enter FETCH.
REQ-040 Reset values: all outputs 0, except memReq, which SHALL be 1 in the first cycle after rst deasserts; trapCause=0, instret=0, wait counter=0.
REQ-041 rst SHALL override every state, including TRAP and mid-request; a pending memory request SHALL be abandoned with no strobe issued.

Verification
REQ-042 add (0110011), memReady=1 constant -> states FETCH, DECODE, EXEC, WB; regsWriteEnable high in cycle 4; wbSel=0, pcSel=0; instret goes 0 to 1.
REQ-043 Load (0000011) with memReady delayed 3 cycles in MEM -> 8 cycles total; memWrite=0 throughout; WB has wbSel=1.
REQ-044 beq (1100011), branchTaken=1 -> pcWriteEnable=1 with pcSel=1 in cycle 3; no regsWriteEnable; next cycle is FETCH.
REQ-045 Opcode 0000000 -> TRAP with trapCause=1; 20 further cycles show no strobes; rst=1 returns to FETCH with trap=0.
REQ-046 MEM_TIMEOUT=4, memReady held 0 in FETCH -> TRAP with trapCause=2 after 4 wait cycles; a repeat with memReady=1 on cycle 4 -> DECODE, no trap.
REQ-047 rst asserted in MEM during a store -> memReq=1 (FETCH, memWrite=0) the next cycle; instret unchanged.
